uart_rx_cfg: RTL and testbench

- Parametrised, runtime-configurable UART receiver with an integrated receive FIFO.
- Successor to the RX half of uart_protocol. Adds a programmable baud divider, 3-sample majority voting at mid-bit, and runtime parity and stop-bit selection.
- Provides sticky error flags with explicit clear.
- Sits between the serial pin and the bus-side register interface.

---
 rtl/uart_rx_cfg.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable UART receiver with mid-bit majority voting and receive FIFO
module uart_rx_cfg #(
  parameter int DATA_SIZE  = 8,
  parameter int SIZE_FIFO  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int BAUD_DIV_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BAUD_DIV_W-1:0] baud_div,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  input  logic                  serial_data_in,
  input  logic                  read_data,
  input  logic                  clear_errors,
  output logic [DATA_SIZE-1:0]  bus_data_out,
  output logic [7:0]            RX_status_register
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_SIZE + 1);
  localparam int PW = $clog2(SIZE_FIFO);
  localparam int CW = $clog2(SIZE_FIFO + 1);
  localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync2_q, prev_q;
  logic [BAUD_DIV_W-1:0] div_cnt_q, div_cnt_d, div_lat_q, div_lat_d;
  logic [1:0]            pmode_q, pmode_d;
  logic                  two_stop_q, two_stop_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [1:0]            smp_q, smp_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic [DATA_SIZE-1:0]  mem_q [SIZE_FIFO];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]  bus_q, bus_d;
  logic [4:0]            err_q, err_d;
  logic [7:0]            status_q, status_d;

  logic line, tick, mid, end_bit, maj, parity_en, par_err, is_break;
  logic push, do_push, do_pop, stop_ev, par_ev, brk_ev, ovf_ev, rnr_ev;

  assign line      = sync2_q;
  assign tick      = (div_cnt_q == div_lat_q);
  assign mid       = tick && (tick_q == T_S2);
  assign end_bit   = tick && (tick_q == T_END);
  assign maj       = (smp_q[0] & smp_q[1]) | (line & (smp_q[0] | smp_q[1]));
  assign parity_en = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign par_err   = parity_en && ((^shift_q ^ par_q) != pmode_q[1]);
  assign is_break  = (shift_q == '0) && (!parity_en || !par_q) && !maj;

  always_comb begin
    state_d    = state_q;
    div_lat_d  = div_lat_q;
    pmode_d    = pmode_q;
    two_stop_d = two_stop_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    smp_d      = smp_q;
    push       = 1'b0;
    stop_ev    = 1'b0;
    par_ev     = 1'b0;
    brk_ev     = 1'b0;
    div_cnt_d  = tick ? '0 : div_cnt_q + BAUD_DIV_W'(1);
    tick_d     = tick ? ((tick_q == T_END) ? '0 : tick_q + TW'(1)) : tick_q;
    if (tick && tick_q == T_S0) smp_d[0] = line;
    if (tick && tick_q == T_S1) smp_d[1] = line;

    case (state_q)
      IDLE: begin
        // Restarting both counters here phase-aligns sampling to the start edge.
        if (prev_q && !line) begin
          state_d    = START;
          div_cnt_d  = '0;
          tick_d     = '0;
          div_lat_d  = baud_div;
          pmode_d    = parity_mode;
          two_stop_d = two_stop;
          bit_cnt_d  = '0;
          par_d      = 1'b0;
        end
      end
      START: begin
        if (mid && maj)   state_d = IDLE;
        else if (end_bit) state_d = DATA;
      end
      DATA: begin
        if (mid) begin
          shift_d   = {maj, shift_q[DATA_SIZE-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
        if (end_bit && bit_cnt_q == BW'(DATA_SIZE)) state_d = parity_en ? PARITY : STOP1;
      end
      PARITY: begin
        if (mid)     par_d   = maj;
        if (end_bit) state_d = STOP1;
      end
      STOP1: begin
        if (mid) begin
          if (is_break) begin
            brk_ev  = 1'b1;
            state_d = BREAK_WAIT;
          end else begin
            push    = 1'b1;
            stop_ev = !maj;
            par_ev  = par_err;
            if (!two_stop_q) state_d = IDLE;
          end
        end else if (end_bit && two_stop_q) begin
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (mid) begin
          stop_ev = !maj;
          state_d = IDLE;
        end
      end
      BREAK_WAIT: if (line) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    do_pop   = read_data && (cnt_q != '0);
    rnr_ev   = read_data && (cnt_q == '0);
    do_push  = push && ((cnt_q != CW'(SIZE_FIFO)) || do_pop);
    ovf_ev   = push && !do_push;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    bus_d    = do_pop ? mem_q[rd_ptr_q] : bus_q;
    // A new event in the clearing cycle survives the clear.
    err_d    = (clear_errors ? 5'b0 : err_q) | {rnr_ev, ovf_ev, stop_ev, brk_ev, par_ev};
    status_d = {err_d, cnt_d == '0, cnt_d == CW'(SIZE_FIFO), state_d != IDLE};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      div_cnt_q  <= '0;
      div_lat_q  <= '0;
      pmode_q    <= 2'b00;
      two_stop_q <= 1'b0;
      tick_q     <= '0;
      smp_q      <= 2'b11;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      bus_q      <= '0;
      err_q      <= '0;
      status_q   <= 8'h04;
    end else begin
      state_q    <= state_d;
      sync1_q    <= serial_data_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      div_cnt_q  <= div_cnt_d;
      div_lat_q  <= div_lat_d;
      pmode_q    <= pmode_d;
      two_stop_q <= two_stop_d;
      tick_q     <= tick_d;
      smp_q      <= smp_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      bus_q      <= bus_d;
      err_q      <= err_d;
      status_q   <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign bus_data_out       = bus_q;
  assign RX_status_register = status_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - bench for uart_rx_cfg: frame-level reference model plus directed literal checks
module tb_uart_rx_cfg;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = '0;
  logic [1:0]  parity_mode = 2'b00;
  logic        two_stop = 1'b0;
  logic        serial_data_in = 1'b1;
  logic        read_data = 1'b0;
  logic        clear_errors = 1'b0;
  logic [7:0]  bus_data_out;
  logic [7:0]  RX_status_register;

  always #5 clk = ~clk;

  uart_rx_cfg dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .serial_data_in(serial_data_in), .read_data(read_data),
    .clear_errors(clear_errors), .bus_data_out(bus_data_out),
    .RX_status_register(RX_status_register)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;

  // Model: FIFO contents, sticky flags {rnr, ovf, stop, brk, par}, last popped byte.
  logic [7:0] mq[$];
  logic [4:0] m_err = '0;
  logic [7:0] m_bus = '0;

  function automatic logic [7:0] exp_status();
    return {m_err, mq.size() == 0, mq.size() == 8, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (RX_status_register !== exp_status() || bus_data_out !== m_bus) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t status=%h bus=%h expected status=%h bus=%h",
                 $time, RX_status_register, bus_data_out, exp_status(), m_bus);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    chk_en = 1'b1;
    step(n);
    chk_en = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input int n);
    serial_data_in = b;
    step(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input int div, input logic [1:0] pm,
                            input logic ts, input logic bad_par, input logic s1, input logic s2);
    int   bt;
    logic pen, p, brk;
    baud_div    = 16'(div);
    parity_mode = pm;
    two_stop    = ts;
    bt  = (div + 1) * 16;
    pen = (pm == 2'b01) || (pm == 2'b10);
    p   = (^d) ^ pm[1] ^ bad_par;
    drive_bit(1'b0, bt);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
    if (pen) drive_bit(p, bt);
    drive_bit(s1, bt);
    if (ts) drive_bit(s2, bt);
    serial_data_in = 1'b1;
    step(6);
    brk = (d == 8'h00) && (!pen || !p) && !s1;
    if (brk) m_err[1] = 1'b1;
    else begin
      if (mq.size() < 8) mq.push_back(d);
      else m_err[3] = 1'b1;
      if (!s1) m_err[2] = 1'b1;
      if (pen && bad_par) m_err[0] = 1'b1;
      if (ts && !s2) m_err[2] = 1'b1;
    end
  endtask

  task automatic pulse_read();
    read_data = 1'b1;
    if (mq.size() > 0) m_bus = mq.pop_front();
    else m_err[4] = 1'b1;
    step(1);
    read_data = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    m_err = '0;
    step(1);
    clear_errors = 1'b0;
  endtask

  logic [7:0] d;
  logic [1:0] pm;
  int         div;
  logic       ts, bp, s1, s2;

  initial begin
    step(3);
    chk("reset_status", RX_status_register, 8'h04);
    chk("reset_bus", bus_data_out, 8'h00);
    reset = 1'b0;
    idle(8);

    send_frame(8'hA5, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("a5_not_empty", RX_status_register, 8'h00);
    idle(8);
    pulse_read();
    chk("a5_bus", bus_data_out, 8'hA5);
    chk("a5_status", RX_status_register, 8'h04);
    idle(8);

    send_frame(8'h3C, 0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("par_err_status", RX_status_register, 8'h08);
    idle(8);
    pulse_clear();
    chk("par_cleared", RX_status_register, 8'h00);
    pulse_read();
    chk("par_bus", bus_data_out, 8'h3C);
    idle(8);

    parity_mode = 2'b00;
    two_stop    = 1'b0;
    serial_data_in = 1'b0;
    step(15 * 16);
    chk("break_busy", RX_status_register, 8'h15);
    step(5 * 16);
    serial_data_in = 1'b1;
    step(6);
    m_err[1] = 1'b1;
    chk("break_done", RX_status_register, 8'h14);
    idle(8);
    pulse_clear();

    serial_data_in = 1'b0;
    step(3);
    serial_data_in = 1'b1;
    step(16);
    chk("glitch", RX_status_register, 8'h04);
    idle(8);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("fifo_full_ovf", RX_status_register, 8'h42);
    idle(8);
    for (int i = 1; i <= 8; i++) begin
      pulse_read();
      chk("fifo_order", bus_data_out, 8'(i));
    end
    chk("fifo_drained", RX_status_register, 8'h44);
    idle(8);
    pulse_clear();

    pulse_read();
    chk("rnr_status", RX_status_register, 8'h84);
    chk("rnr_bus_hold", bus_data_out, 8'h08);
    idle(8);
    pulse_clear();

    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 8);
    reset = 1'b1;
    serial_data_in = 1'b1;
    mq.delete();
    m_err = '0;
    m_bus = '0;
    step(1);
    chk("midreset_status", RX_status_register, 8'h04);
    chk("midreset_bus", bus_data_out, 8'h00);
    step(2);
    reset = 1'b0;
    idle(8);
    send_frame(8'hC3, 1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(8);
    pulse_read();
    chk("after_reset_bus", bus_data_out, 8'hC3);
    idle(8);

    for (int it = 0; it < 30; it++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      div = $urandom_range(0, 2);
      pm  = 2'($urandom);
      ts  = 1'($urandom_range(0, 1));
      bp  = ($urandom_range(0, 4) == 0);
      s1  = ($urandom_range(0, 5) != 0);
      s2  = ($urandom_range(0, 5) != 0);
      send_frame(d, div, pm, ts, bp, s1, s2);
      idle(8);
      if ($urandom_range(0, 2) != 0) begin
        pulse_read();
        idle(4);
      end
      if ($urandom_range(0, 4) == 0) begin
        pulse_clear();
        idle(4);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
